uart_tx_buffered: RTL and testbench

Buffered 8N1 UART transmitter that consumes the MMIO UART write port: a single-cycle `START` pulse with `DATA` from the wrapper's `UART_DATA_AD` decode enqueues a byte, and the block serialises it onto `TX`. `READY` returns to the MMIO read mux at `UART_RDY_AD`. A small FIFO decouples the 50 MHz CPU clock domain logic from the slow serial line, so firmware can burst several bytes without polling between them.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_fifo.sv | 49 ++++
 rtl/uart_tx_buffered.sv | 138 +++++++++++++
 tb/tb_uart_tx_buffered.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        DATA_BITS  = 3'd2,
        PARITY_BIT = 3'd3,
        STOP_BIT   = 3'd4
    } uart_tx_state_t;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Clock cycles per serial bit, truncating.
    function automatic int uart_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO with read-through head; pointers carry one extra wrap bit
// so that full and empty are distinguishable without a counter.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = UART_DATA_BITS
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // A write while full is dropped even if a pop lands in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter fed by single-cycle START strobes.
// Define UART_TX_PARITY_EN to insert an even parity bit (8E1 frames).
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic [7:0] DATA,
    output logic       READY,
    output logic       BUSY,
    output logic       TX
);

    localparam int             DIV  = uart_div(CLK_HZ, BAUD);
    localparam int             TW   = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0]  TMAX = TW'(DIV - 1);

    if (DIV < 2) begin : g_div_chk
        $error("uart_tx_buffered: CLK_HZ / BAUD must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
        $error("uart_tx_buffered: FIFO_DEPTH must be a power of two >= 2");
    end

    uart_tx_state_t state;
    uart_tx_state_t state_n;
    logic [TW-1:0]  timer;
    logic [2:0]     bit_idx;
    logic [7:0]     shift;
    logic [7:0]     shift_n;
    logic [7:0]     head;
    logic           tx_q;
    logic           tx_d;
    logic           bit_end;
    logic           last_bit;
    logic           push;
    logic           pop;
    logic           full;
    logic           empty;
`ifdef UART_TX_PARITY_EN
    logic           par_q;
`endif

    assign bit_end  = (timer == TMAX);
    assign last_bit = (bit_idx == 3'(UART_DATA_BITS - 1));
    assign push     = START && READY;
    assign READY    = !full;
    assign BUSY     = (state != IDLE) || !empty;
    assign TX       = tx_q;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .CLK   (CLK),
        .RST_N (RST_N),
        .push  (push),
        .pop   (pop),
        .din   (DATA),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:       if (!empty) state_n = START_BIT;
            START_BIT:  if (bit_end) state_n = DATA_BITS;
            DATA_BITS:
                if (bit_end && last_bit) begin
`ifdef UART_TX_PARITY_EN
                    state_n = PARITY_BIT;
`else
                    state_n = STOP_BIT;
`endif
                end
            PARITY_BIT: if (bit_end) state_n = STOP_BIT;
            // Chain straight into the next start bit to keep frames gapless.
            STOP_BIT:   if (bit_end) state_n = empty ? IDLE : START_BIT;
            default:    state_n = IDLE;
        endcase
    end

    // TX is registered from the upcoming state so the line changes on the
    // same edge as the state it represents.
    always_comb begin
        pop     = !empty && ((state == IDLE) || (state == STOP_BIT && bit_end));
        shift_n = shift;
        if (pop)
            shift_n = head;
        else if (state == DATA_BITS && bit_end)
            shift_n = shift >> 1;

        case (state_n)
            START_BIT:  tx_d = 1'b0;
            DATA_BITS:  tx_d = shift_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY_BIT: tx_d = par_q;
`endif
            default:    tx_d = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_q    <= UART_IDLE_LEVEL;
        end else begin
            shift <= shift_n;
            tx_q  <= tx_d;
            if (state == IDLE || pop || bit_end) timer <= '0;
            else                                 timer <= timer + 1'b1;
            if (state != DATA_BITS) bit_idx <= '0;
            else if (bit_end)       bit_idx <= bit_idx + 1'b1;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)   par_q <= 1'b0;
        else if (pop) par_q <= ^head;
    end
`endif

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: vector table plus hand sequences,
// with a line decoder that checks every cycle of each frame against a scoreboard.
module tb_uart_tx_buffered;

    localparam int CLK_HZ = 1000;
    localparam int BAUD   = 100;
    localparam int DEPTH  = 4;
    localparam int DIV    = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS  = 11;
`else
    localparam int NBITS  = 10;
`endif
    localparam int FRAME  = NBITS * DIV;

    logic       CLK   = 1'b0;
    logic       RST_N = 1'b0;
    logic       START = 1'b0;
    logic [7:0] DATA  = 8'h00;
    logic       READY;
    logic       BUSY;
    logic       TX;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] exp_q  [$];
    int         starts [$];

    typedef struct {
        logic [7:0] data;
        int         lat;
        int         busy;
    } vec_t;

    vec_t vecs [7];

    uart_tx_buffered #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (START),
        .DATA  (DATA),
        .READY (READY),
        .BUSY  (BUSY),
        .TX    (TX)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {2'b11, b, 1'b0};
`endif
    endfunction

    // Line decoder: each start bit pops the scoreboard and every cycle of
    // the frame must carry the expected level.
    initial begin : monitor
        logic [7:0]  b;
        logic [10:0] fr;
        logic [10:0] got;
        bit          ok;
        bit          aborted;
        forever begin
            @(negedge CLK);
            if (RST_N === 1'b1 && TX === 1'b0) begin
                starts.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: start bit at cycle %0d with empty scoreboard", cyc);
                    b = 8'h00;
                end else begin
                    b = exp_q.pop_front();
                end
                fr      = frame_of(b);
                got     = '0;
                ok      = 1'b1;
                aborted = 1'b0;
                for (int k = 0; k < FRAME; k++) begin
                    if (k > 0) @(negedge CLK);
                    if (RST_N !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (TX !== fr[k / DIV]) ok = 1'b0;
                    if (k % DIV == DIV / 2) got[k / DIV] = TX;
                end
                if (!aborted) begin
                    checks++;
                    if (!ok) begin
                        errors++;
                        $display("FAIL frame_%02h: line bits %b expected %b", b,
                                 got[NBITS-1:0], fr[NBITS-1:0]);
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit accept);
        @(negedge CLK);
        START = 1'b1;
        DATA  = d;
        if (accept) exp_q.push_back(d);
        @(posedge CLK);
        #1 START = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        while (BUSY !== 1'b0 && n < limit) begin
            @(negedge CLK);
            n++;
        end
        if (BUSY !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL %s: BUSY still high after %0d cycles", name, limit);
        end
    endtask

    task automatic single(input vec_t v);
        int lat = 0;
        int cnt = 0;
        send(v.data, 1'b1);
        do begin
            @(posedge CLK);
            lat++;
            @(negedge CLK);
        end while (TX !== 1'b0 && lat < 20);
        chk($sformatf("lat_%02h", v.data), lat, v.lat);
        chk($sformatf("ready_%02h", v.data), int'(READY), 1);
        while (BUSY === 1'b1 && cnt < 4 * FRAME) begin
            cnt++;
            @(negedge CLK);
        end
        chk($sformatf("busy_len_%02h", v.data), cnt, v.busy);
        chk($sformatf("tx_idle_%02h", v.data), int'(TX), 1);
    endtask

    initial begin : stim
        int bad;
        int cnt;
        int n0;
        int busy_end;

        vecs[0] = '{8'h55, 1, FRAME};
        vecs[1] = '{8'h00, 1, FRAME};
        vecs[2] = '{8'hFF, 1, FRAME};
        vecs[3] = '{8'hA5, 1, FRAME};
        vecs[4] = '{8'h07, 1, FRAME};
        vecs[5] = '{8'h03, 1, FRAME};
        vecs[6] = '{8'h80, 1, FRAME};

        // Reset values
        repeat (3) @(negedge CLK);
        chk("rst_tx",    int'(TX),    1);
        chk("rst_ready", int'(READY), 1);
        chk("rst_busy",  int'(BUSY),  0);
        RST_N = 1'b1;

        bad = 0;
        repeat (500) begin
            @(negedge CLK);
            if (TX !== 1'b1 || BUSY !== 1'b0) bad++;
        end
        chk("idle_500", bad, 0);

        foreach (vecs[i]) single(vecs[i]);

        // Burst of five into a four-deep FIFO, sixth byte dropped
        n0 = starts.size();
        for (int i = 0; i < 5; i++) begin
            send(8'(i + 1), 1'b1);
            chk($sformatf("burst_ready_%0d", i), int'(READY), (i < 4) ? 1 : 0);
        end
        send(8'hFF, 1'b0);
        chk("drop_ready", int'(READY), 0);
        wait_idle("burst_drain", 8 * FRAME);
        busy_end = cyc;
        chk("burst_frames", starts.size() - n0, 5);
        if (starts.size() >= n0 + 5) begin
            chk("burst_span", starts[n0 + 4] - starts[n0], 4 * FRAME);
            chk("burst_total", busy_end - starts[n0], 5 * FRAME);
        end
        chk("burst_sb_empty", exp_q.size(), 0);

        // Reset in the middle of data bit 3 of 8'hA5
        send(8'hA5, 1'b1);
        cnt = 0;
        do begin
            @(negedge CLK);
            cnt++;
        end while (TX !== 1'b0 && cnt < 20);
        repeat (4 * DIV + 4) @(negedge CLK);
        chk("mid_bit3", int'(TX), 0);
        #2 RST_N = 1'b0;
        #1;
        chk("rst_mid_tx",    int'(TX),    1);
        chk("rst_mid_ready", int'(READY), 1);
        chk("rst_mid_busy",  int'(BUSY),  0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        chk("rst_mid_sb", exp_q.size(), 0);
        bad = 0;
        repeat (30) begin
            @(negedge CLK);
            if (TX !== 1'b1 || BUSY !== 1'b0) bad++;
        end
        chk("post_rst_idle", bad, 0);
        single('{8'h3C, 1, FRAME});

        // Push landing on the same edge as the stop-bit pop
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        send(8'h33, 1'b1);
        repeat (FRAME - 2) @(posedge CLK);
        send(8'h44, 1'b1);
        chk("simul_ready", int'(READY), 1);
        @(negedge CLK);
        chk("simul_next_start", int'(TX), 0);
        send(8'h55, 1'b1);
        chk("simul_ready_3", int'(READY), 1);
        send(8'h66, 1'b1);
        chk("simul_ready_full", int'(READY), 0);
        wait_idle("simul_drain", 8 * FRAME);
        chk("simul_sb_empty", exp_q.size(), 0);

        repeat (5) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
